// File: rtl/alu_pkg.sv
// Shared types for the round-robin ALU sequencer: opcodes, request and
// response records, sequencer states and the divide-by-zero result value.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_DIV = 3'b011,
      OP_OR  = 3'b100,
      OP_XOR = 3'b101,
      OP_AND = 3'b110,
      OP_NOT = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      alu_op_e    op;
   } alu_req_t;

   typedef struct packed {
      logic [15:0] result;
      logic        err;
   } alu_rsp_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } seq_state_e;

   localparam logic [15:0] DIV0_RESULT = 16'hFFFF;

endpackage

// File: rtl/alu_exec_unit.sv
// Purely combinational 8-bit ALU: operands are zero-extended to 16 bits and
// a divide by zero returns DIV0_RESULT with the error flag raised.
module alu_exec_unit
   import alu_pkg::*;
(
   input  alu_req_t req,
   output alu_rsp_t rsp
);

   logic [15:0] a_ext;
   logic [15:0] b_ext;

   assign a_ext = {8'h00, req.a};
   assign b_ext = {8'h00, req.b};

   // Evaluate the selected operation; only a zero divisor sets the error flag
   always_comb begin
      rsp.result = '0;
      rsp.err    = 1'b0;
      case (req.op)
         OP_ADD: rsp.result = a_ext + b_ext;
         OP_SUB: rsp.result = a_ext - b_ext;
         OP_MUL: rsp.result = a_ext * b_ext;
         OP_DIV: begin
            if (req.b == 8'h00) begin
               rsp.result = DIV0_RESULT;
               rsp.err    = 1'b1;
            end else begin
               rsp.result = a_ext / b_ext;
            end
         end
         OP_OR:   rsp.result = a_ext | b_ext;
         OP_XOR:  rsp.result = a_ext ^ b_ext;
         OP_AND:  rsp.result = a_ext & b_ext;
         OP_NOT:  rsp.result = {8'h00, ~req.a};
         default: rsp.result = '0;
      endcase
   end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one ALU between NUM_REQ requesters.
// Each operation walks IDLE (grant) -> EXEC (compute) -> RESP (hand back).
// Optional macro ALU_STATS_EN adds the op_count port counting completed ops.
module alu_rr_sequencer
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*8-1:0] req_a,
   input  logic [NUM_REQ*8-1:0] req_b,
   input  logic [NUM_REQ*3-1:0] req_op,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [15:0]          rsp_result,
   output logic                 rsp_err,
   output logic                 busy
`ifdef ALU_STATS_EN
   ,
   output logic [15:0]          op_count
`endif
);

   seq_state_e      state;
   seq_state_e      state_next;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] cand;
   logic [ID_W-1:0] grant_idx;
   logic            grant_found;
   alu_req_t        grant_req;
   alu_req_t        cur_req;
   logic [ID_W-1:0] cur_id;
   alu_rsp_t        exec_rsp;

   // Index arithmetic modulo NUM_REQ, valid for non-power-of-two counts
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                input int              offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NUM_REQ) begin
         sum = sum - NUM_REQ;
      end
      return sum[ID_W-1:0];
   endfunction

   // Scan requests upward from rr_ptr with wrap; the first valid one wins
   always_comb begin
      cand        = '0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = wrap_add(rr_ptr, i);
         if (!grant_found && req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Pick out the winner's operands from the packed request buses
   always_comb begin
      grant_req    = '0;
      grant_req.a  = req_a[8*grant_idx +: 8];
      grant_req.b  = req_b[8*grant_idx +: 8];
      grant_req.op = alu_op_e'(req_op[3*grant_idx +: 3]);
   end

   alu_exec_unit u_exec (
      .req (cur_req),
      .rsp (exec_rsp)
   );

   // Next state and the single-cycle grant strobe, only raised while idle
   always_comb begin
      state_next = state;
      req_ready  = '0;
      case (state)
         ST_IDLE: begin
            if (grant_found) begin
               req_ready[grant_idx] = 1'b1;
               state_next           = ST_EXEC;
            end
         end
         ST_EXEC: state_next = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State, pointer, latched operands and response registers; reset drops any op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         rr_ptr     <= '0;
         cur_req    <= '0;
         cur_id     <= '0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            ST_IDLE: begin
               if (grant_found) begin
                  cur_req <= grant_req;
                  cur_id  <= grant_idx;
                  rr_ptr  <= wrap_add(grant_idx, 1);
               end
            end
            ST_EXEC: begin
               rsp_result <= exec_rsp.result;
               rsp_err    <= exec_rsp.err;
               rsp_id     <= cur_id;
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE);

`ifdef ALU_STATS_EN
   // Count completed response handshakes, wrapping naturally at 16 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= '0;
      end else if (rsp_valid && rsp_ready) begin
         op_count <= op_count + 16'd1;
      end
   end
`endif

endmodule
